camera_config_seq: RTL

- Sequencer that walks the OV7670 configuration ROM from address 0 and issues one SCCB register write per entry to the SCCB master.
- Handles two in-band markers: 16'hFF_F0 (timed delay, e.g. after soft reset) and 16'hFF_FF (end of table).
- Sits between the top-level camera init trigger, the registered config ROM (1-cycle read latency) and the SCCB write master.
- Reports busy/done/error status to the capture pipeline, which stays disabled until done.

---
 rtl/camera_config_seq_if.sv | 22 ++
 rtl/camera_config_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/camera_config_seq_if.sv
// SCCB write request/response channel between the config sequencer and the SCCB master.
interface camera_config_seq_if;
    logic       o_sccb_valid;
    logic       i_sccb_ready;
    logic [7:0] o_sccb_dev;
    logic [7:0] o_sccb_reg;
    logic [7:0] o_sccb_data;
    logic       i_sccb_done;
    logic       i_sccb_nack;

    // Sequencer side: issues requests, sees acceptance and completion.
    modport master (
        output o_sccb_valid, o_sccb_dev, o_sccb_reg, o_sccb_data,
        input  i_sccb_ready, i_sccb_done, i_sccb_nack
    );

    // SCCB master side.
    modport slave (
        input  o_sccb_valid, o_sccb_dev, o_sccb_reg, o_sccb_data,
        output i_sccb_ready, i_sccb_done, i_sccb_nack
    );
endinterface

// File: rtl/camera_config_seq.sv
// OV7670 configuration sequencer: walks the config ROM from address 0 and
// issues one SCCB register write per entry, honouring the in-band markers
// 16'hFFF0 (timed delay) and 16'hFFFF (end of table).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for i_start after reset
// S_FETCH  | two cycles, ROM address held while the registered ROM reads
// S_DECODE | classify ROM word: end marker, delay marker or register write
// S_SEND   | write request presented until the SCCB master accepts it
// S_WAIT   | waiting for the completion pulse, retry on NACK
// S_DELAY  | timed pause, no SCCB traffic
// S_NEXT   | advance ROM address, stop after the last address
// S_DONE   | table finished, capture may start
// S_ERROR  | entry failed after all retries, address points at it
//
// DELAY_CYCLES must be at least 1.
module camera_config_seq #(
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter int unsigned DELAY_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_start,
    output logic [7:0]                 o_rom_addr,
    input  logic [15:0]                i_rom_data,
    camera_config_seq_if.master        sccb,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [7:0]                 o_wr_count
);
    localparam int DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [15:0] MARK_END   = 16'hFFFF;
    localparam logic [15:0] MARK_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SEND, S_WAIT,
        S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         reg_q, reg_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic               fetch_q, fetch_d;

    // State and datapath registers; reset aborts any run immediately.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            dly_q   <= '0;
            fetch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            dly_q   <= dly_d;
            fetch_q <= fetch_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        dly_d   = dly_q;
        fetch_d = fetch_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    cnt_d   = '0;
                    retry_d = '0;
                    fetch_d = 1'b0;
                end
            end
            S_FETCH: begin
                fetch_d = ~fetch_q;
                if (fetch_q) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (i_rom_data == MARK_END) begin
                    state_d = S_DONE;
                end else if (i_rom_data == MARK_DELAY) begin
                    state_d = S_DELAY;
                    dly_d   = DLY_W'(DELAY_CYCLES - 1);
                end else begin
                    state_d = S_SEND;
                    reg_d   = i_rom_data[15:8];
                    data_d  = i_rom_data[7:0];
                end
            end
            S_SEND: begin
                if (sccb.i_sccb_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sccb.i_sccb_done) begin
                    if (!sccb.i_sccb_nack) begin
                        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                        retry_d = '0;
                        state_d = S_NEXT;
                    end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_SEND;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == '0) state_d = S_NEXT;
                else             dly_d   = dly_q - DLY_W'(1);
            end
            S_NEXT: begin
                if (addr_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state, so they are glitch-free.
    always_comb begin
        sccb.o_sccb_valid = (state_q == S_SEND);
        sccb.o_sccb_dev   = DEV_ADDR;
        sccb.o_sccb_reg   = reg_q;
        sccb.o_sccb_data  = data_q;
        o_rom_addr        = addr_q;
        o_wr_count        = cnt_q;
        o_done            = (state_q == S_DONE);
        o_err             = (state_q == S_ERROR);
        o_busy            = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    end
endmodule
